button_status_panel: RTL

//  Parametrised successor of the push-button status display. It debounces N_CH

---
 rtl/button_status_panel.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/button_status_panel.sv
// Debounced N_CH status buttons plus a sound button, resolved into a status code.
// Also drives an accepted-press counter, a 4-digit scanned 7-segment display and a beeper.
module button_status_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync  <= '0;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module button_status_panel #(
  parameter int N_CH            = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SCAN_CYCLES     = 50000,
  parameter int BEEP_CYCLES     = 5000000,
  parameter int LATCH_MODE      = 1,
  parameter int ACTIVE_LOW      = 1,
  localparam int SW             = $clog2(N_CH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] btn,
  input  logic            sound,
  output logic [SW-1:0]   state,
  output logic [7:0]      presses,
  output logic [3:0]      digit,
  output logic [7:0]      seg,
  output logic            buzzer
);
  localparam int BW  = $clog2(BEEP_CYCLES + 1);
  localparam int SCW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;

  generate
    if (N_CH < 1 || N_CH > 15) begin : g_bad_n_ch
      $error("button_status_panel: N_CH must be in 1..15");
    end
  endgenerate

  logic [N_CH:0]   d_all;
  logic [N_CH-1:0] d, d_prev, ev;
  logic            d_sound;
  logic [SW-1:0]   winner, held_code;
  logic [BW-1:0]   beep_cnt;
  logic [SCW-1:0]  scan_cnt;
  logic [1:0]      scan_idx;
  logic [6:0]      glyph;
  logic [3:0]      onehot;

  // Sound rides along as the top lane so all inputs share one debouncer array.
  button_status_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb [N_CH:0] (
    .clk  (clk),
    .reset(reset),
    .raw  ({sound, btn}),
    .level(d_all)
  );

  assign d       = d_all[N_CH-1:0];
  assign d_sound = d_all[N_CH];
  assign ev      = d & ~d_prev;

  // Descending loops so the lowest index is written last and wins.
  always_comb begin
    winner    = '0;
    held_code = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (ev[i]) winner = SW'(i + 1);
      if (d[i])  held_code = SW'(i + 1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_prev   <= '0;
      state    <= '0;
      presses  <= '0;
      beep_cnt <= '0;
      buzzer   <= 1'b0;
    end else begin
      d_prev <= d;
      if (LATCH_MODE != 0) begin
        if (|ev) state <= winner;
      end else begin
        state <= held_code;
      end
      if (|ev) presses <= presses + 1'b1;
      if (|ev)                 beep_cnt <= BW'(BEEP_CYCLES);
      else if (beep_cnt != '0) beep_cnt <= beep_cnt - 1'b1;
      buzzer <= (beep_cnt != '0) | d_sound;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else if (scan_cnt == SCW'(SCAN_CYCLES - 1)) begin
      scan_cnt <= '0;
      scan_idx <= scan_idx + 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  function automatic logic [6:0] hex_font(input logic [3:0] v);
    case (v)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  always_comb begin
    onehot = 4'b0001 << scan_idx;
    case (scan_idx)
      2'd0:    glyph = hex_font(4'(state));
      2'd1:    glyph = hex_font(presses[3:0]);
      2'd2:    glyph = hex_font(presses[7:4]);
      default: glyph = (state == '0) ? 7'h40 : 7'h00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit <= (ACTIVE_LOW != 0) ? 4'hF : 4'h0;
      seg   <= (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    end else begin
      digit <= (ACTIVE_LOW != 0) ? ~onehot : onehot;
      seg   <= (ACTIVE_LOW != 0) ? ~{1'b0, glyph} : {1'b0, glyph};
    end
  end
endmodule
